// File: rtl/encrypt_frame_sched_if.sv
// Signal bundle between the two payload sources, the frame scheduler and the
// downstream serial encryptor. The scheduler uses the slave modport; whatever
// drives requests/payload and observes the encryptor side uses master.
interface encrypt_frame_sched_if #(
    parameter int LEN_W = 8
);
    logic [1:0]       i_req;
    logic [LEN_W-1:0] i_len0;
    logic [LEN_W-1:0] i_len1;
    logic             i_data0;
    logic             i_data1;
    logic [1:0]       o_gnt;
    logic [1:0]       o_data_rd;
    logic             o_enc_clr;
    logic             o_enc_data;
    logic             o_enc_vld;
    logic             o_busy;

    modport master (
        output i_req, i_len0, i_len1, i_data0, i_data1,
        input  o_gnt, o_data_rd, o_enc_clr, o_enc_data, o_enc_vld, o_busy
    );

    modport slave (
        input  i_req, i_len0, i_len1, i_data0, i_data1,
        output o_gnt, o_data_rd, o_enc_clr, o_enc_data, o_enc_vld, o_busy
    );
endinterface

// File: rtl/encrypt_frame_sched.sv
// Frame scheduler sharing one serial encryptor between two payload sources.
// Round-robin arbitration, a one-cycle encryptor clear at frame start, then a
// fixed sync word followed by the granted source's payload bits.
// Optional feature: define ENC_FRAME_PARITY_EN to append an even-parity bit
// (PAR state) after the payload.
module encrypt_frame_sched #(
    parameter int                LEN_W     = 8,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
    parameter int                GAP_CYC   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    encrypt_frame_sched_if.slave bus
);
    localparam int SIDX_W = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;
    localparam int CNT_W  = (LEN_W > SIDX_W) ? LEN_W : SIDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_SYNC, S_PAY, S_PAR, S_GAP
    } state_t;

`ifdef ENC_FRAME_PARITY_EN
    localparam state_t S_POST_PAY = S_PAR;
`else
    localparam state_t S_POST_PAY = S_GAP;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0] r_len;
    logic             r_sel, w_sel_nxt;
    logic             r_last;
    logic             w_win;
    logic             w_cnt_zero;
    logic             w_pay_bit;
    logic [1:0]       w_sel_oh;

    logic [1:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_data_rd, w_rd_nxt;
    logic             r_enc_clr, w_clr_nxt;
    logic             r_enc_data, w_dat_nxt;
    logic             r_enc_vld, w_vld_nxt;
    logic             r_busy, w_busy_nxt;

`ifdef ENC_FRAME_PARITY_EN
    logic             r_par;
    logic             w_par_fin;
    // Final parity must include the bit being consumed in the last PAY cycle.
    assign w_par_fin = (r_state == S_PAY) ? (r_par ^ w_pay_bit) : r_par;
`endif

    assign w_cnt_zero = (r_cnt == '0);
    assign w_pay_bit  = r_sel ? bus.i_data1 : bus.i_data0;
    assign w_sel_oh   = w_sel_nxt ? 2'b10 : 2'b01;

    // Round-robin pick: a lone request wins, a tie goes to the source not granted last.
    always_comb begin
        w_win = 1'b0;
        case (bus.i_req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    // Next-state, bit counter and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: if (|bus.i_req) begin
                w_state_nxt = S_ARB;
                w_sel_nxt   = w_win;
            end
            S_ARB:  w_state_nxt = S_SYNC;
            S_SYNC: if (w_cnt_zero) w_state_nxt = (r_len == '0) ? S_POST_PAY : S_PAY;
            S_PAY:  if (w_cnt_zero) w_state_nxt = S_POST_PAY;
`ifdef ENC_FRAME_PARITY_EN
            S_PAR:  w_state_nxt = S_GAP;
`endif
            S_GAP:  if (w_cnt_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Count down, reload on every state entry, hold at zero (never wraps).
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_SYNC:  w_cnt_nxt = CNT_W'(SYNC_W - 1);
                S_PAY:   w_cnt_nxt = CNT_W'(r_len) - CNT_W'(1);
                S_GAP:   w_cnt_nxt = CNT_W'(GAP_CYC - 1);
                default: w_cnt_nxt = '0;
            endcase
        end else begin
            w_cnt_nxt = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        end

        // NOTE: outputs are decoded from the next state and registered, so
        // o_enc_clr/o_gnt come straight off flops and cannot glitch.
        w_gnt_nxt  = 2'b00;
        w_rd_nxt   = 2'b00;
        w_clr_nxt  = 1'b0;
        w_dat_nxt  = 1'b0;
        w_vld_nxt  = 1'b0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_ARB: begin
                w_gnt_nxt = w_sel_oh;
                w_clr_nxt = 1'b1;
            end
            S_SYNC: begin
                w_gnt_nxt = w_sel_oh;
                w_vld_nxt = 1'b1;
                w_dat_nxt = SYNC_WORD[w_cnt_nxt[SIDX_W-1:0]];
            end
            S_PAY: begin
                w_gnt_nxt = w_sel_oh;
                w_rd_nxt  = w_sel_oh;
                w_vld_nxt = 1'b1;
            end
`ifdef ENC_FRAME_PARITY_EN
            S_PAR: begin
                w_gnt_nxt = w_sel_oh;
                w_vld_nxt = 1'b1;
                w_dat_nxt = w_par_fin;
            end
`endif
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath: counter, sampled length, grant select, round-robin pointer, outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_gnt      <= 2'b00;
            r_data_rd  <= 2'b00;
            r_enc_clr  <= 1'b0;
            r_enc_data <= 1'b0;
            r_enc_vld  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            if (r_state == S_IDLE && (|bus.i_req)) begin
                r_len  <= w_win ? bus.i_len1 : bus.i_len0;
                r_last <= w_win;
            end
            r_gnt      <= w_gnt_nxt;
            r_data_rd  <= w_rd_nxt;
            r_enc_clr  <= w_clr_nxt;
            r_enc_data <= w_dat_nxt;
            r_enc_vld  <= w_vld_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

`ifdef ENC_FRAME_PARITY_EN
    // Running XOR of payload bits, cleared at every frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  r_par <= 1'b0;
        else if (r_state == S_ARB)  r_par <= 1'b0;
        else if (r_state == S_PAY)  r_par <= r_par ^ w_pay_bit;
    end
`endif

    // Payload bits pass combinationally to the encryptor; everything else is a flop.
    assign bus.o_enc_data = (r_state == S_PAY) ? w_pay_bit : r_enc_data;
    assign bus.o_gnt      = r_gnt;
    assign bus.o_data_rd  = r_data_rd;
    assign bus.o_enc_clr  = r_enc_clr;
    assign bus.o_enc_vld  = r_enc_vld;
    assign bus.o_busy     = r_busy;
endmodule
